// File: rtl/set_button_pulser.sv
// Debounced up/down pushbutton front end for the clock's set counters.
// Emits one inc/dec pulse per press, then auto-repeats while the button stays held.
module set_button_pulser #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int REP_CYCLES  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic inc,
    output logic dec,
    output logic repeating
);

    localparam int MAX_AB = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int MAXC   = (MAX_AB > REP_CYCLES) ? MAX_AB : REP_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        HOLD   = 3'd2,
        REPEAT = 3'd3,
        REL    = 3'd4,
        LOCK   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          pulse;
    logic [1:0]    up_sync, dn_sync;
    logic          up_s, dn_s;
    logic          own, other;

    assign up_s  = up_sync[1];
    assign dn_s  = dn_sync[1];
    // "own" is the button that started this press, "other" the opposite one
    assign own   = dir_q ? up_s : dn_s;
    assign other = dir_q ? dn_s : up_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pulse   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (up_s && dn_s) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end else if (up_s || dn_s) begin
                    state_d = ARM;
                    dir_d   = up_s;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM: begin
                if (!own) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (other) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    pulse   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!own) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (other) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    pulse   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REPEAT: begin
                if (!own) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (other) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REL: begin
                // any bounce during release restarts the quiet-period count
                if (up_s || dn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOCK: begin
                if (!up_s && !dn_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_sync   <= 2'b00;
            dn_sync   <= 2'b00;
            state_q   <= REL;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            inc       <= 1'b0;
            dec       <= 1'b0;
            repeating <= 1'b0;
        end else begin
            up_sync   <= {up_sync[0], btn_up};
            dn_sync   <= {dn_sync[0], btn_dn};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            inc       <= pulse & dir_q;
            dec       <= pulse & ~dir_q;
            repeating <= (state_d == REPEAT);
        end
    end

endmodule

// File: tb/tb_set_button_pulser.sv
// Scenario bench for set_button_pulser: expected pulse edges are queued when a
// press is driven and consumed as the DUT output is sampled.
module tb_set_button_pulser;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_dn;
    logic inc;
    logic dec;
    logic repeating;

    int vectors = 0;
    int miscompares = 0;
    int inc_q[$];
    int dec_q[$];

    localparam logic [2:0] ENC_REL  = 3'd4;
    localparam logic [2:0] ENC_LOCK = 3'd5;

    set_button_pulser #(
        .DEB_CYCLES (4),
        .HOLD_CYCLES(8),
        .REP_CYCLES (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .inc      (inc),
        .dec      (dec),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    task automatic quiet_cycles(input int n);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({inc, dec, repeating} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got inc/dec/rep=%b expected 000", {inc, dec, repeating});
        end
        rst = 1'b0;
        quiet_cycles(4);
    endtask

    // Single up press held through edge 8: one inc after edge 5, nothing else.
    task automatic test_single_press(input bit up);
        if (up) inc_q.push_back(5);
        else    dec_q.push_back(5);
        for (int k = 0; k < 16; k++) begin
            btn_up = up && (k <= 8);
            btn_dn = !up && (k <= 8);
            @(posedge clk);
            #1;
            begin
                bit ei, ed;
                ei = (inc_q.size() > 0 && inc_q[0] == k);
                ed = (dec_q.size() > 0 && dec_q[0] == k);
                if (ei) void'(inc_q.pop_front());
                if (ed) void'(dec_q.pop_front());
                vectors++;
                if (inc !== ei || dec !== ed) begin
                    miscompares++;
                    $display("[TB] FAIL single_press(up=%0d) edge %0d: got inc=%b dec=%b expected inc=%b dec=%b",
                             up, k, inc, dec, ei, ed);
                end
            end
        end
        quiet_cycles(6);
    endtask

    // Button sampled high at edges 0..27; FSM sees the release at edge 30.
    task automatic test_auto_repeat;
        int pulses[7] = '{5, 13, 16, 19, 22, 25, 28};
        foreach (pulses[i]) inc_q.push_back(pulses[i]);
        for (int k = 0; k < 40; k++) begin
            btn_up = (k <= 27);
            btn_dn = 1'b0;
            @(posedge clk);
            #1;
            begin
                bit ei, er;
                ei = (inc_q.size() > 0 && inc_q[0] == k);
                if (ei) void'(inc_q.pop_front());
                er = (k >= 13 && k <= 29);
                vectors++;
                if (inc !== ei || dec !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL auto_repeat_pulse edge %0d: got inc=%b dec=%b expected inc=%b dec=0",
                             k, inc, dec, ei);
                end
                vectors++;
                if (repeating !== er) begin
                    miscompares++;
                    $display("[TB] FAIL auto_repeat_flag edge %0d: got repeating=%b expected %b", k, repeating, er);
                end
            end
        end
        quiet_cycles(4);
    endtask

    // Down button high for only two samples: rejected as a bounce.
    task automatic test_bounce;
        for (int k = 0; k < 12; k++) begin
            btn_up = 1'b0;
            btn_dn = (k <= 1);
            @(posedge clk);
            #1;
            vectors++;
            if (inc !== 1'b0 || dec !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bounce edge %0d: got inc=%b dec=%b expected 0 0", k, inc, dec);
            end
        end
        test_single_press(1'b0);
    endtask

    // Up held, down joins during HOLD: only the first inc, then lock until both released.
    task automatic test_lock;
        inc_q.push_back(5);
        for (int k = 0; k < 34; k++) begin
            btn_up = (k <= 24);
            btn_dn = (k >= 7 && k <= 24);
            @(posedge clk);
            #1;
            begin
                bit ei;
                ei = (inc_q.size() > 0 && inc_q[0] == k);
                if (ei) void'(inc_q.pop_front());
                vectors++;
                if (inc !== ei || dec !== 1'b0 || repeating !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL lock edge %0d: got inc=%b dec=%b rep=%b expected inc=%b dec=0 rep=0",
                             k, inc, dec, repeating, ei);
                end
            end
        end
        test_single_press(1'b1);
    endtask

    // Up held across a reset that lands on the pulse edge: no inc until re-press.
    task automatic test_reset_held;
        for (int k = 0; k < 34; k++) begin
            btn_up = (k <= 25);
            btn_dn = 1'b0;
            rst    = (k == 5 || k == 6);
            @(posedge clk);
            #1;
            vectors++;
            if (inc !== 1'b0 || dec !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_held edge %0d: got inc=%b dec=%b expected 0 0", k, inc, dec);
            end
        end
        rst = 1'b0;
        test_single_press(1'b1);
    endtask

    task automatic test_random;
        bit prev_inc = 1'b0;
        bit prev_dec = 1'b0;
        logic [2:0] prev_state;
        int rate = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c % 64 == 0) rate = $urandom_range(0, 3);
            if ($urandom_range(0, 31) < rate * 3) btn_up = ~btn_up;
            if ($urandom_range(0, 31) < rate * 2) btn_dn = ~btn_dn;
            prev_state = dut.state_q;
            @(posedge clk);
            #1;
            vectors++;
            if ((inc && dec) || (inc && prev_inc) || (dec && prev_dec) ||
                ((inc || dec) && (prev_state == ENC_REL || prev_state == ENC_LOCK))) begin
                miscompares++;
                $display("[TB] FAIL random_invariant cycle %0d: got inc=%b dec=%b prev inc=%b dec=%b prev_state=%0d",
                         c, inc, dec, prev_inc, prev_dec, prev_state);
            end
            prev_inc = inc;
            prev_dec = dec;
        end
        quiet_cycles(8);
    endtask

    initial begin
        btn_up = 1'b0;
        btn_dn = 1'b0;
        rst    = 1'b1;
        test_reset();
        test_single_press(1'b1);
        test_auto_repeat();
        test_bounce();
        test_lock();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
